alu_issue_stage: RTL

Sequential front-end that sits directly upstream of the combinational datapath ALU and feeds it. It accepts one operation per valid/ready handshake, registers the operands, and drives the ALU's one-hot function-select lines and carry-in. It then captures the ALU result, zout and cout, maintains the processor Z/C status flags, and presents the result to the register-writeback stage through a second valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Sequential front-end for the combinational datapath ALU. It
//            accepts one operation per cmd handshake and registers the
//            operands. It drives the one-hot ALU function select and the
//            carry-in, then captures the ALU result and zout/cout. It keeps
//            the Z/C status flags and offers the result to writeback through
//            a res handshake.
// Ports    : clk, ExternalReset (async, active high)
//            cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_use_c : command in
//            alu_A/alu_B/alu_sel/alu_cin                      : to ALU
//            aluout/zout/cout                                 : from ALU
//            res_valid/res_ready/res_data/res_err             : result out
//            Zflag/Cflag                                      : status flags
//            CSet/CReset/ZSet/ZReset                          : flag pulses
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_W     = 16,
    parameter int OP_W       = 4,
    parameter bit C_ON_LOGIC = 1'b0
) (
    input  logic              clk,
    input  logic              ExternalReset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_c,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [9:0]        alu_sel,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] aluout,
    input  logic              zout,
    input  logic              cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              Zflag,
    output logic              Cflag,
    input  logic              CSet,
    input  logic              CReset,
    input  logic              ZSet,
    input  logic              ZReset
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_aluA;
    logic [DATA_W-1:0]   r_aluB;
    logic [9:0]          r_aluSel;
    logic                r_aluCin;
    logic                r_opIllegal;
    logic                r_opLoadsC;
    logic [DATA_W-1:0]   r_resData;
    logic                r_resErr;
    logic                r_resValid;
    logic                r_cmdReady;
    logic                r_z;
    logic                r_c;

    logic [9:0]          w_selDecode;
    logic                w_opIllegal;
    logic                w_opLoadsC;
    logic                w_accept;
    logic                w_capture;
    logic                w_zCap;
    logic                w_cCap;
    logic                w_zNext;
    logic                w_cNext;

    // Opcode to one-hot select; bit 9 is B15to0 (op 0), bit 0 is AcmpB (op 9).
    always_comb begin
        w_selDecode = 10'b0;
        case (cmd_op)
            OP_W'(0): w_selDecode = 10'b10_0000_0000;
            OP_W'(1): w_selDecode = 10'b01_0000_0000;
            OP_W'(2): w_selDecode = 10'b00_1000_0000;
            OP_W'(3): w_selDecode = 10'b00_0100_0000;
            OP_W'(4): w_selDecode = 10'b00_0010_0000;
            OP_W'(5): w_selDecode = 10'b00_0001_0000;
            OP_W'(6): w_selDecode = 10'b00_0000_1000;
            OP_W'(7): w_selDecode = 10'b00_0000_0100;
            OP_W'(8): w_selDecode = 10'b00_0000_0010;
            OP_W'(9): w_selDecode = 10'b00_0000_0001;
            default:  w_selDecode = 10'b0;
        endcase
    end

    assign w_opIllegal = (cmd_op > OP_W'(9));
    // Only add, sub and cmp produce a meaningful carry unless logic ops are
    // configured to load C as well.
    assign w_opLoadsC  = C_ON_LOGIC ? !w_opIllegal
                                    : ((cmd_op == OP_W'(6)) ||
                                       (cmd_op == OP_W'(7)) ||
                                       (cmd_op == OP_W'(9)));

    assign w_accept  = (r_state == S_IDLE) && cmd_valid && r_cmdReady;

    // The ALU result is captured on the edge that closes EXEC.
    assign w_capture = (r_state == S_EXEC) && !r_opIllegal;
    assign w_zCap    = w_capture ? zout : r_z;
    assign w_cCap    = (w_capture && r_opLoadsC) ? cout : r_c;

    // Direct pulses override the capture; Reset wins over Set.
    assign w_zNext   = ZReset ? 1'b0 : (ZSet ? 1'b1 : w_zCap);
    assign w_cNext   = CReset ? 1'b0 : (CSet ? 1'b1 : w_cCap);

    always_ff @(posedge clk or posedge ExternalReset) begin
        if (ExternalReset) begin
            r_state     <= S_IDLE;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluSel    <= '0;
            r_aluCin    <= 1'b0;
            r_opIllegal <= 1'b0;
            r_opLoadsC  <= 1'b0;
            r_resData   <= '0;
            r_resErr    <= 1'b0;
            r_resValid  <= 1'b0;
            r_cmdReady  <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
        end else begin
            r_z <= w_zNext;
            r_c <= w_cNext;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_aluA      <= cmd_a;
                        r_aluB      <= cmd_b;
                        r_aluSel    <= w_selDecode;
                        // r_c is the flag value before this edge, so a CSet
                        // landing on the accept edge does not reach this op.
                        r_aluCin    <= cmd_use_c & r_c;
                        r_opIllegal <= w_opIllegal;
                        r_opLoadsC  <= w_opLoadsC;
                        r_cmdReady  <= 1'b0;
                        r_state     <= S_EXEC;
                    end else begin
                        r_cmdReady  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_resData  <= aluout;
                    r_resErr   <= r_opIllegal;
                    r_aluSel   <= '0;
                    r_resValid <= 1'b1;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    // Ready rises only after the result handshake edge, so
                    // no command is taken in the same cycle.
                    if (res_ready) begin
                        r_resValid <= 1'b0;
                        r_cmdReady <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_aluSel   <= '0;
                    r_resValid <= 1'b0;
                    r_cmdReady <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmdReady;
    assign alu_A     = r_aluA;
    assign alu_B     = r_aluB;
    assign alu_sel   = r_aluSel;
    assign alu_cin   = r_aluCin;
    assign res_valid = r_resValid;
    assign res_data  = r_resData;
    assign res_err   = r_resErr;
    assign Zflag     = r_z;
    assign Cflag     = r_c;

endmodule
`default_nettype wire
